// File: rtl/jtag_bsr_pkg.sv
// Shared types and sizing helpers for the boundary-scan register.
package jtag_bsr_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    EXTEST = 2'd1,
    CLAMP  = 2'd2,
    SAMPLE = 2'd3
  } bsr_mode_e;

  // Counter must represent 0..WIDTH+1, the top value flagging an overrun.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/jtag_bsr_cell.sv
// One boundary cell: shift flop with capture/shift mux, update flop, pin mux.
module jtag_bsr_cell
  import jtag_bsr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       safe_i,
  input  logic       capture_i,
  input  logic       shift_i,
  input  logic       ser_i,
  input  logic       par_i,
  input  logic       upd_en_i,
  input  logic [1:0] mode_i,
  output logic       sreg_o,
  output logic       pout_o
);

  logic sreg_q, sreg_d;
  logic ureg_q;

  always_comb begin
    sreg_d = sreg_q;
    if (capture_i)    sreg_d = par_i;
    else if (shift_i) sreg_d = ser_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= 1'b0;
      ureg_q <= safe_i;
    end else begin
      sreg_q <= sreg_d;
      if (upd_en_i) ureg_q <= sreg_q;
    end
  end

  always_comb begin
    pout_o = par_i;
    case (bsr_mode_e'(mode_i))
      EXTEST:  pout_o = ureg_q;
      CLAMP:   pout_o = safe_i;
      default: pout_o = par_i;
    endcase
  end

  assign sreg_o = sreg_q;

endmodule

// File: rtl/jtag_boundary_register.sv
// Boundary-scan register: WIDTH cells in a chain, with a shift counter that
// gates updates so only a complete scan reaches the pins in strict mode.
module jtag_boundary_register
  import jtag_bsr_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] SAFE_VALUE    = '0,
  parameter bit               STRICT_UPDATE = 1'b1,
  localparam int              CW            = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             captureDR,
  input  logic             shiftDR,
  input  logic             updateDR,
  input  logic [1:0]       mode,
  input  logic             shiftIN,
  output logic             shiftOUT,
  input  logic [WIDTH-1:0] parallelIN,
  output logic [WIDTH-1:0] parallelOUT,
  output logic [CW-1:0]    shiftCount,
  output logic             updateDone,
  output logic             updateError
);

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  // chain[i] is cell i's shift flop; chain[WIDTH] is the TDI entry point.
  logic [WIDTH:0] chain;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, err_q;
  logic           upd_ok;

  assign chain[WIDTH] = shiftIN;
  assign upd_ok = updateDR && (!STRICT_UPDATE || (cnt_q == CNT_FULL));

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jtag_bsr_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .safe_i    (SAFE_VALUE[i]),
      .capture_i (captureDR),
      .shift_i   (shiftDR),
      .ser_i     (chain[i+1]),
      .par_i     (parallelIN[i]),
      .upd_en_i  (upd_ok),
      .mode_i    (mode),
      .sreg_o    (chain[i]),
      .pout_o    (parallelOUT[i])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (captureDR)                       cnt_d = '0;
    else if (shiftDR && cnt_q < CNT_SAT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= upd_ok;
      err_q  <= updateDR && !upd_ok;
    end
  end

  assign shiftOUT    = chain[0];
  assign shiftCount  = cnt_q;
  assign updateDone  = done_q;
  assign updateError = err_q;

endmodule

// File: tb/tb_jtag_boundary_register.sv
// Bench for jtag_boundary_register: strict and non-strict instances driven
// in parallel and compared against a bit-vector/counter reference model.
module tb_jtag_boundary_register;
  localparam int         W    = 8;
  localparam logic [7:0] SAFE = 8'hA5;
  localparam int         CW   = $clog2(W + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          captureDR, shiftDR, updateDR, shiftIN;
  logic [1:0]    mode;
  logic [W-1:0]  parallelIN;
  logic          so_s, so_n, done_s, done_n, err_s, err_n;
  logic [W-1:0]  pout_s, pout_n;
  logic [CW-1:0] cnt_s, cnt_n;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [W-1:0] m_sreg, m_ureg_s, m_ureg_n;
  int           m_cnt;
  logic         m_done_s, m_err_s, m_done_n;

  always #5 clk = ~clk;

  jtag_boundary_register #(.WIDTH(W), .SAFE_VALUE(SAFE), .STRICT_UPDATE(1'b1)) dut (
    .clk(clk), .rst(rst), .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR),
    .mode(mode), .shiftIN(shiftIN), .shiftOUT(so_s), .parallelIN(parallelIN),
    .parallelOUT(pout_s), .shiftCount(cnt_s), .updateDone(done_s), .updateError(err_s));

  jtag_boundary_register #(.WIDTH(W), .SAFE_VALUE(SAFE), .STRICT_UPDATE(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR),
    .mode(mode), .shiftIN(shiftIN), .shiftOUT(so_n), .parallelIN(parallelIN),
    .parallelOUT(pout_n), .shiftCount(cnt_n), .updateDone(done_n), .updateError(err_n));

  function automatic logic [W-1:0] exp_pout(input logic [1:0] md, input logic [W-1:0] u,
                                            input logic [W-1:0] pin);
    case (md)
      2'd1:    return u;
      2'd2:    return SAFE;
      default: return pin;
    endcase
  endfunction

  task automatic model_reset();
    m_sreg = '0; m_ureg_s = SAFE; m_ureg_n = SAFE; m_cnt = 0;
    m_done_s = 0; m_err_s = 0; m_done_n = 0;
  endtask

  // One clock: model consumes the pre-edge inputs and state, then settle 1ns.
  task automatic tick();
    @(posedge clk);
    m_done_s = updateDR && (m_cnt == W);
    m_err_s  = updateDR && (m_cnt != W);
    m_done_n = updateDR;
    if (m_done_s) m_ureg_s = m_sreg;
    if (updateDR) m_ureg_n = m_sreg;
    if (captureDR) begin
      m_sreg = parallelIN;
      m_cnt  = 0;
    end else if (shiftDR) begin
      m_sreg = (m_sreg >> 1) | (W'(shiftIN) << (W - 1));
      if (m_cnt < W + 1) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic idle();
    captureDR = 0; shiftDR = 0; updateDR = 0; shiftIN = 0;
  endtask

  task automatic capture(input logic [W-1:0] pin);
    parallelIN = pin; captureDR = 1; tick(); captureDR = 0;
  endtask

  task automatic shift_n(input int n, input logic [W-1:0] data);
    shiftDR = 1;
    for (int i = 0; i < n; i++) begin
      shiftIN = data[i % W];
      tick();
    end
    shiftDR = 0; shiftIN = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); mode = 2'd1; parallelIN = '0; model_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++; if (pout_s !== SAFE) begin errors++; $display("FAIL reset_pout got %h exp %h", pout_s, SAFE); end
    checks++; if (so_s !== 1'b0) begin errors++; $display("FAIL reset_shiftout got %b exp 0", so_s); end
    checks++; if (cnt_s !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt_s); end
    checks++; if ({done_s, err_s, done_n, err_n} !== 4'b0) begin errors++;
      $display("FAIL reset_pulses got %b exp 0000", {done_s, err_s, done_n, err_n}); end
    rst = 0;
  endtask

  task automatic test_shift_out();
    logic [W-1:0] seq;
    seq = 8'h3C;
    capture(8'h3C);
    shiftDR = 1; shiftIN = 0;
    for (int i = 0; i < W; i++) begin
      checks++; if (so_s !== seq[i]) begin errors++; $display("FAIL shift_seq bit%0d got %b exp %b", i, so_s, seq[i]); end
      tick();
    end
    shiftDR = 0;
    checks++; if (cnt_s !== CW'(W)) begin errors++; $display("FAIL shift_count got %0d exp %0d", cnt_s, W); end
  endtask

  task automatic test_update();
    capture(8'h00); shift_n(W, 8'h5A);
    mode = 2'd1; updateDR = 1; tick(); updateDR = 0;
    checks++; if (done_s !== 1'b1 || err_s !== 1'b0) begin errors++;
      $display("FAIL update_pulse got done=%b err=%b exp done=1 err=0", done_s, err_s); end
    checks++; if (pout_s !== 8'h5A) begin errors++; $display("FAIL update_pout got %h exp 5a", pout_s); end
    tick();
    checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL update_pulse_len got %b exp 0", done_s); end
  endtask

  task automatic test_strict_reject();
    capture(8'hFF); shift_n(W - 1, 8'h33);
    updateDR = 1; tick(); updateDR = 0;
    checks++; if (err_s !== 1'b1 || done_s !== 1'b0) begin errors++;
      $display("FAIL short_scan_err got err=%b done=%b exp err=1 done=0", err_s, done_s); end
    checks++; if (pout_s !== 8'h5A) begin errors++; $display("FAIL short_scan_hold got %h exp 5a", pout_s); end
    checks++; if (done_n !== 1'b1 || pout_n !== m_ureg_n) begin errors++;
      $display("FAIL nonstrict_commit got done=%b pout=%h exp done=1 pout=%h", done_n, pout_n, m_ureg_n); end
    capture(8'h00); shift_n(10, 8'hC3);
    checks++; if (cnt_s !== CW'(W + 1)) begin errors++; $display("FAIL count_sat got %0d exp %0d", cnt_s, W + 1); end
    updateDR = 1; tick(); updateDR = 0;
    checks++; if (err_s !== 1'b1 || pout_s !== 8'h5A) begin errors++;
      $display("FAIL overrun_reject got err=%b pout=%h exp err=1 pout=5a", err_s, pout_s); end
  endtask

  task automatic test_cap_priority();
    logic [W-1:0] got;
    parallelIN = 8'hF0; captureDR = 1; shiftDR = 1; shiftIN = 1; tick(); idle();
    checks++; if (cnt_s !== '0) begin errors++; $display("FAIL cap_prio_count got %0d exp 0", cnt_s); end
    shiftDR = 1;
    for (int i = 0; i < W; i++) begin got[i] = so_s; tick(); end
    shiftDR = 0;
    checks++; if (got !== 8'hF0) begin errors++; $display("FAIL cap_prio_sreg got %h exp f0", got); end
    mode = 2'd2; #1;
    checks++; if (pout_s !== SAFE) begin errors++; $display("FAIL clamp got %h exp %h", pout_s, SAFE); end
    mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      parallelIN = W'($urandom); #1;
      checks++; if (pout_s !== parallelIN) begin errors++; $display("FAIL normal_track got %h exp %h", pout_s, parallelIN); end
    end
  endtask

  task automatic test_async_reset();
    mode = 2'd1;
    capture(8'hE7); shift_n(4, 8'h0F);
    #2 rst = 1; model_reset(); #1;
    checks++; if (so_s !== 1'b0 || cnt_s !== '0 || pout_s !== SAFE) begin errors++;
      $display("FAIL async_rst got so=%b cnt=%0d pout=%h exp so=0 cnt=0 pout=%h", so_s, cnt_s, pout_s, SAFE); end
    #1 rst = 0;
    updateDR = 1; tick(); updateDR = 0;
    checks++; if (err_s !== 1'b1 || pout_s !== SAFE) begin errors++;
      $display("FAIL rst_then_update got err=%b pout=%h exp err=1 pout=%h", err_s, pout_s, SAFE); end
  endtask

  // Random scans (near-complete lengths) interleaved with random per-cycle enables.
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (c % 10 == 0) begin
        captureDR = 1; shiftDR = 0; updateDR = 0;
      end else if (c % 10 == 9 || $urandom_range(0, 15) == 0) begin
        captureDR = ($urandom_range(0, 7) == 0); shiftDR = $urandom_range(0, 1); updateDR = 1;
      end else begin
        captureDR = 0; shiftDR = ($urandom_range(0, 7) != 0); updateDR = 0;
      end
      shiftIN = $urandom_range(0, 1); mode = 2'($urandom_range(0, 3)); parallelIN = W'($urandom);
      tick();
      checks++;
      if (so_s !== m_sreg[0] || cnt_s !== CW'(m_cnt) || done_s !== m_done_s || err_s !== m_err_s ||
          pout_s !== exp_pout(mode, m_ureg_s, parallelIN)) begin
        errors++;
        $display("FAIL rand_strict c%0d got so=%b cnt=%0d d=%b e=%b pout=%h exp so=%b cnt=%0d d=%b e=%b pout=%h",
                 c, so_s, cnt_s, done_s, err_s, pout_s, m_sreg[0], m_cnt, m_done_s, m_err_s,
                 exp_pout(mode, m_ureg_s, parallelIN));
      end
      checks++;
      if (so_n !== m_sreg[0] || done_n !== m_done_n || err_n !== 1'b0 ||
          pout_n !== exp_pout(mode, m_ureg_n, parallelIN)) begin
        errors++;
        $display("FAIL rand_nonstrict c%0d got so=%b d=%b e=%b pout=%h exp so=%b d=%b e=0 pout=%h",
                 c, so_n, done_n, err_n, pout_n, m_sreg[0], m_done_n, exp_pout(mode, m_ureg_n, parallelIN));
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_shift_out();
    test_update();
    test_strict_reject();
    test_cap_priority();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
